dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
Two-master arbiter sharing the single data-RAM port (addr/we/dataIn/dataOut) between master 0 (CPU data port, stalled via ack) and master 1 (debug/IO loader that fills and reads back operand and result words).
- Round-robin arbitration with optional locked bursts, bounded by MAX_BURST.
- Saturating per-master access counters.
- Sits between the masters and the data RAM; one RAM access per cycle.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_BURST, 4, maximum consecutive locked grants to one master while the other is requesting (>=1)
CW, 16, access counter width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
m0_req  in  1  master 0 access request
m0_lock  in  1  master 0 requests to hold grant next cycle
m0_addr  in  AW  master 0 address
m0_we  in  1  master 0 write enable
m0_wdata  in  DW  master 0 write data
m0_rdata  out  DW  read data, valid when m0_ack=1
m0_ack  out  1  master 0 access performed this cycle
m1_req, m1_lock, m1_addr, m1_we, m1_wdata, m1_rdata, m1_ack: same as m0_*, for master 1
mem_addr  out  AW  RAM address
mem_we  out  1  RAM write enable
mem_wdata  out  DW  RAM write data
mem_rdata  in  DW  RAM combinational read data
owner  out  1  index of master granted this cycle (valid when busy=1)
busy  out  1  a grant is issued this cycle
cnt0  out  CW  master 0 acks since reset, saturating
cnt1  out  CW  master 1 acks since reset, saturating

Behaviour:
- Grant decision is combinational from the current requests and registered state. Zero latency: ack, mem_* and rdata all in the same cycle as req. The RAM write commits at the clk edge ending that cycle.
- Registered state: st in {IDLE, HOLD0, HOLD1}; last (index of last granted master); bcnt (0..MAX_BURST).
- Round-robin rule (RR), applied in IDLE:
  - Both req: grant !last.
  - One req: grant it.
  - None: no grant.
- In HOLDx:
  - mx_req=1 and bcnt<MAX_BURST: grant x.
  - Else: apply RR with last=x. If the other master is requesting it wins; if not, x may be granted again, starting a new burst.
- Next state after a grant to x:
  - Continuing a HOLDx burst: bcnt+1.
  - New grant: bcnt=1.
  - If mx_lock=1, st=HOLDx; else st=IDLE, bcnt=0.
  - last=x in all cases.
- No grant: st=IDLE, bcnt=0, last unchanged.
- Lock with req=0 is ignored.
- At most one ack per cycle.
- Granted master's addr/we/wdata drive mem_*. With no grant: mem_addr=0, mem_wdata=0, mem_we=0.
- m0_rdata=m1_rdata=mem_rdata always; masters use rdata only when acked.
- Counters increment on the corresponding ack and hold at all-ones.
- While reset=0 (asynchronous):
  - st=IDLE, last=1 (master 0 wins first tie), bcnt=0, cnt0=cnt1=0.
  - Acks, busy and mem_we are forced 0 combinationally.
- Reset asserted mid-burst discards the lock. The first cycle after release behaves as IDLE.
- Non-requesting master's ack stays 0 regardless of its addr/we.

Test Plan:
1. Reset low, both req=1 with m0_we=1 -> m0_ack=m1_ack=0, mem_we=0, cnt0=cnt1=0. Release reset with both req held, no lock -> acks alternate m0,m1,m0,m1; cnt0=cnt1=2 after 4 cycles.
2. m1 only, write 0x0000_0005 to addr 0x10, next cycle read 0x10 -> m1_ack=1 both cycles, mem_we=1 then 0, m1_rdata=0x0000_0005; m0_ack=0.
3. m0 req+lock held continuously, m1 req from cycle 0, MAX_BURST=4 -> m0 acked cycles 0-3, m1 cycle 4, m0 cycles 5-8, m1 cycle 9.
4. m0 req+lock, m1 idle for 10 cycles -> m0 acked all 10 cycles; busy=1, owner=0 throughout.
5. Reset asserted during cycle 2 of an m1 locked burst with m0 waiting, released next cycle with both req -> first grant goes to m0 (last=1 reloaded), st IDLE.
6. CW=2, m0 requesting alone for 5 cycles -> cnt0 sequence 1,2,3,3,3.

Source files
------------

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - two-master round-robin arbiter with locked bursts for the data RAM port
module dram_arbiter #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m0_lock,
  input  logic [AW-1:0] m0_addr,
  input  logic          m0_we,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_ack,
  input  logic          m1_req,
  input  logic          m1_lock,
  input  logic [AW-1:0] m1_addr,
  input  logic          m1_we,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_ack,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          owner,
  output logic          busy,
  output logic [CW-1:0] cnt0,
  output logic [CW-1:0] cnt1
);

  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, HOLD0, HOLD1} state_t;

  state_t        st, st_nxt;
  logic          last, last_nxt;
  logic [BW-1:0] bcnt, bcnt_nxt;
  logic          rr_last;
  logic          gnt0, gnt1, cont;
  logic          g0, g1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st   <= IDLE;
      last <= 1'b1;
      bcnt <= '0;
    end else begin
      st   <= st_nxt;
      last <= last_nxt;
      bcnt <= bcnt_nxt;
    end
  end

  always_comb begin
    rr_last  = last;
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    cont     = 1'b0;
    st_nxt   = IDLE;
    bcnt_nxt = '0;
    last_nxt = last;
    // a burst holder keeps the port until it drops req or hits MAX_BURST
    case (st)
      HOLD0: begin
        rr_last = 1'b0;
        if (m0_req && bcnt < BW'(MAX_BURST)) begin
          gnt0 = 1'b1;
          cont = 1'b1;
        end
      end
      HOLD1: begin
        rr_last = 1'b1;
        if (m1_req && bcnt < BW'(MAX_BURST)) begin
          gnt1 = 1'b1;
          cont = 1'b1;
        end
      end
      default: ;
    endcase
    if (!gnt0 && !gnt1) begin
      if (m0_req && m1_req) begin
        gnt0 = rr_last;
        gnt1 = !rr_last;
      end else begin
        gnt0 = m0_req;
        gnt1 = m1_req;
      end
    end
    g0 = gnt0 & reset;
    g1 = gnt1 & reset;
    if (g0 || g1) begin
      last_nxt = g1;
      if (g0 ? m0_lock : m1_lock) begin
        st_nxt   = g1 ? HOLD1 : HOLD0;
        bcnt_nxt = cont ? bcnt + BW'(1) : BW'(1);
      end
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (g0) begin
      mem_addr  = m0_addr;
      mem_we    = m0_we;
      mem_wdata = m0_wdata;
    end else if (g1) begin
      mem_addr  = m1_addr;
      mem_we    = m1_we;
      mem_wdata = m1_wdata;
    end
  end

  assign m0_ack   = g0;
  assign m1_ack   = g1;
  assign busy     = g0 | g1;
  assign owner    = g1;
  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (g0 && cnt0 != '1) cnt0 <= cnt0 + CW'(1);
      if (g1 && cnt1 != '1) cnt1 <= cnt1 + CW'(1);
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - scoreboard bench for dram_arbiter
module tb_dram_arbiter;

  typedef struct {
    logic a0;
    logic a1;
    logic we;
    logic chk_rd;
    logic [31:0] rd;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_lock, m0_we;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_ack;
  logic        m1_req, m1_lock, m1_we;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;
  logic        owner, busy;
  logic [15:0] cnt0, cnt1;

  logic        r2, s_req;
  logic [31:0] s_m0_rdata, s_m1_rdata, s_mem_addr, s_mem_wdata;
  logic        s_m0_ack, s_m1_ack, s_mem_we, s_owner, s_busy;
  logic [1:0]  s_cnt0, s_cnt1;

  logic [31:0] ram [0:255];
  exp_t        exp_q[$];
  int          n_checks;
  int          n_fail;
  int          exp_cnt0, exp_cnt1;

  dram_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .CW(16)) u_dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_lock(m0_lock), .m0_addr(m0_addr), .m0_we(m0_we),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_lock(m1_lock), .m1_addr(m1_addr), .m1_we(m1_we),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .owner(owner), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  dram_arbiter #(.AW(32), .DW(32), .MAX_BURST(4), .CW(2)) u_sat (
    .clk(clk), .reset(r2),
    .m0_req(s_req), .m0_lock(1'b0), .m0_addr(32'h0), .m0_we(1'b0),
    .m0_wdata(32'h0), .m0_rdata(s_m0_rdata), .m0_ack(s_m0_ack),
    .m1_req(1'b0), .m1_lock(1'b0), .m1_addr(32'h0), .m1_we(1'b0),
    .m1_wdata(32'h0), .m1_rdata(s_m1_rdata), .m1_ack(s_m1_ack),
    .mem_addr(s_mem_addr), .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(32'h0),
    .owner(s_owner), .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = ram[mem_addr[7:0]];
  always @(posedge clk) if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // push the expectation for this cycle, then compare mid-cycle and advance
  task automatic exp_cycle(input logic a0, input logic a1, input logic we,
                           input logic chk_rd, input logic [31:0] rd);
    exp_t e;
    e.a0 = a0; e.a1 = a1; e.we = we; e.chk_rd = chk_rd; e.rd = rd;
    exp_q.push_back(e);
    if (a0) exp_cnt0++;
    if (a1) exp_cnt1++;
    @(negedge clk);
    e = exp_q.pop_front();
    check("m0_ack", 64'(m0_ack), 64'(e.a0));
    check("m1_ack", 64'(m1_ack), 64'(e.a1));
    check("busy", 64'(busy), 64'(e.a0 | e.a1));
    check("mem_we", 64'(mem_we), 64'(e.we));
    if (e.a0 | e.a1) check("owner", 64'(owner), 64'(e.a1));
    else begin
      check("mem_addr_idle", 64'(mem_addr), 64'h0);
      check("mem_wdata_idle", 64'(mem_wdata), 64'h0);
    end
    if (e.chk_rd) begin
      check("m0_rdata", 64'(m0_rdata), 64'(e.rd));
      check("m1_rdata", 64'(m1_rdata), 64'(e.rd));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_cnt0"}, 64'(cnt0), 64'(exp_cnt0));
    check({tag, "_cnt1"}, 64'(cnt1), 64'(exp_cnt1));
  endtask

  initial begin
    logic [1:0] sat_seq [5];
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    n_checks = 0; n_fail = 0; exp_cnt0 = 0; exp_cnt1 = 0;
    reset = 1'b0; r2 = 1'b0; s_req = 1'b0;
    m0_req = 0; m0_lock = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_lock = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    #1;

    // reset held: both requesting, nothing may be granted
    m0_req = 1; m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hAA;
    m1_req = 1; m1_addr = 32'h20;
    exp_cycle(0, 0, 0, 0, 0);
    exp_cycle(0, 0, 0, 0, 0);
    check_cnts("reset");
    reset = 1'b1;
    exp_cycle(1, 0, 1, 0, 0);
    exp_cycle(0, 1, 0, 1, 32'hAA);
    exp_cycle(1, 0, 1, 0, 0);
    exp_cycle(0, 1, 0, 1, 32'hAA);
    check_cnts("alternate");
    check("cnt0_is_2", 64'(cnt0), 64'd2);

    // master 1 alone: write then read back
    m0_req = 0; m0_we = 0;
    m1_addr = 32'h10; m1_wdata = 32'h5; m1_we = 1;
    exp_cycle(0, 1, 1, 0, 0);
    m1_we = 0;
    exp_cycle(0, 1, 0, 1, 32'h5);

    // locked m0 burst against a waiting m1
    m0_req = 1; m0_lock = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      if (c == 4 || c == 9) exp_cycle(0, 1, 0, 1, 32'h5);
      else                  exp_cycle(1, 0, 0, 1, 32'hAA);
    end
    check_cnts("burst");

    // locked m0 alone keeps the port past MAX_BURST
    m1_req = 0; m0_addr = 32'h30;
    for (int c = 0; c < 10; c++) exp_cycle(1, 0, 0, 0, 0);
    m0_req = 0; m0_lock = 0;
    exp_cycle(0, 0, 0, 0, 0);
    check_cnts("solo");

    // reset in the middle of an m1 burst drops the lock
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_lock = 1;
    exp_cycle(0, 1, 0, 0, 0);
    exp_cycle(0, 1, 0, 0, 0);
    reset = 1'b0;
    exp_cnt0 = 0; exp_cnt1 = 0;
    exp_cycle(0, 0, 0, 0, 0);
    check_cnts("midreset");
    reset = 1'b1;
    exp_cycle(1, 0, 0, 1, 32'hAA);
    exp_cycle(0, 1, 0, 1, 32'h5);
    check_cnts("after_reset");

    // CW=2 counter saturates at 3
    m0_req = 0; m1_req = 0; m1_lock = 0;
    r2 = 1'b1; s_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("sat_cnt0_%0d", i), 64'(s_cnt0), 64'(sat_seq[i]));
    end
    check("sat_cnt1", 64'(s_cnt1), 64'd0);
    check("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
